rysy_mem: RTL
=============

# rysy_mem

Memory-side responder for the rysy core data/instruction bus. Accepts the core's `addr`/`wdata`/`we`/`be` requests and returns registered `rdata` one cycle later. Contains a byte-lane-writable word RAM plus a small memory-mapped peripheral window: output port, free-running timer, compare, and status. Sits beside `rysy_core` at top level, closing the loop on its memory interface.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; power of two, 16..65536.
- `TIMER_DIV`, 1: timer prescale; timer advances once per `TIMER_DIV` clocks, range 1..65535.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `addr`  in  32  byte address from core; `addr[1:0]` ignored, lanes selected by `be`.
- `wdata`  in  32  write data, lane i = bits [8i+7:8i].
- `we`  in  1  write strobe, sampled at rising edge.
- `be`  in  4  byte enables; qualifies writes only, reads always return full word.
- `rdata`  out  32  registered read data.
- `gpio_out`  out  8  output port register.
- `irq`  out  1  timer match flag (STATUS bit0).
- `bus_err`  out  1  sticky unmapped-access flag.

## Operation
- Address decode on `addr[31:28]`: 0x0 = RAM; 0x8 = peripheral window; all else unmapped.
- RAM: word index `addr[log2(MEM_WORDS)+1:2]`; any `addr[27:log2(MEM_WORDS)+2]` bit set = unmapped.
- Peripheral window (`addr[27:4]` must be 0, else unmapped), offset `addr[3:2]`:
  - 0 GPIO: RW, bits [7:0]; upper bits read 0.
  - 1 TIMER: RW 32-bit counter.
  - 2 CMP: RW 32-bit compare.
  - 3 STATUS: bit0 match flag, write-1-to-clear; bits [31:1] read 0.
- Peripheral writes honour `be` per lane; GPIO writes only lane 0.
- Write with `be`=0000: no state change, not an error.
- Unmapped: read returns 0x0000_0000, write ignored, `bus_err` set (stays 1 until reset).
- Timer: prescaler counts 0..TIMER_DIV-1; at terminal count TIMER increments, wraps 0xFFFF_FFFF -> 0.
- Match: when TIMER (post-update value) equals CMP, STATUS bit0 set.

## Timing
- Read latency 1: `rdata` at edge N+1 reflects `addr` sampled at edge N; held until next edge.
- Every edge updates `rdata` (no enable); reads have no side effects.
- Write effective at the sampling edge; read-during-write same address returns old data (read-first).
- Simultaneous TIMER write and increment: write wins, prescaler restarts at 0.
- Simultaneous match set and STATUS clear: set wins, flag remains 1.
- CMP write taking effect at same edge as equality: match evaluated against new CMP next cycle.
- Reset (async, on `rst` low): `rdata`=0, `gpio_out`=0, TIMER=0, prescaler=0, CMP=0xFFFF_FFFF, STATUS=0, `irq`=0, `bus_err`=0. RAM contents not reset. A write sampled while `rst` low is dropped.
- Release of `rst` is synchronised by the top level; first valid access edge is the first rising edge with `rst` high.

## Configuration
- `RYSY_MEM_TIMER_EN` defined: TIMER, CMP, STATUS, prescaler and `irq` implemented as above.
- Undefined: offsets 1..3 read 0, writes ignored without setting `bus_err`; `irq` tied 0; `TIMER_DIV` unused. GPIO and RAM unaffected.

## Test plan
- Reset then read RAM 0x0000_0010 after writing 0xDEAD_BEEF with be=1111 -> `rdata`=0xDEAD_BEEF exactly one cycle after read address.
- Write 0x1122_3344 be=1111, then 0xAABB_CCDD be=0101 same address -> readback 0x11BB_33DD; write be=0000 -> unchanged.
- Read 0x9000_0000 and write 0x8000_0010 -> `rdata`=0, `bus_err`=1, held across further valid accesses until `rst` low.
- TIMER_DIV=4, write CMP=3 after reset -> TIMER reaches 3 after 12 clocks, `irq`=1; write STATUS=1 -> `irq`=0 next cycle.
- Write TIMER=0xFFFF_FFFF, TIMER_DIV=1 -> next read returns 0x0000_0000 (wrap); write GPIO=0x0000_01A5 -> `gpio_out`=0xA5.
- Assert `rst` low mid-write -> all outputs reset values immediately, RAM word unchanged.

Source files
------------

// File: rtl/rysy_mem.sv
// rysy_mem: word RAM plus GPIO/timer peripheral window on the rysy core bus.
// Define RYSY_MEM_TIMER_EN to build TIMER, CMP, STATUS and irq.
module rysy_mem #(
    parameter int MEM_WORDS = 1024,
    parameter int TIMER_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic [7:0]  gpio_out,
    output logic        irq,
    output logic        bus_err
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] widx;
    logic [25:0]   ram_hi;
    logic [1:0]    off;
    logic [31:0]   bmask;
    logic          ram_sel;
    logic          per_sel;
    logic          ram_we;
    logic          unused_bits;

    logic [31:0] rdata_d, rdata_q;
    logic [7:0]  gpio_d, gpio_q;
    logic        err_d, err_q;

    assign widx    = addr[AW+1:2];
    assign ram_hi  = addr[27:2] >> AW;
    assign off     = addr[3:2];
    assign ram_sel = (addr[31:28] == 4'h0) && (ram_hi == '0);
    assign per_sel = (addr[31:28] == 4'h8) && (addr[27:4] == 24'h0);
    assign bmask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign unused_bits = ^addr[1:0];

    // Writes seen while reset is asserted must not touch the array.
    assign ram_we = rst && we && ram_sel;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef RYSY_MEM_TIMER_EN
    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    logic [PW-1:0] pre_d, pre_q;
    logic [31:0]   timer_d, timer_q;
    logic [31:0]   cmp_d, cmp_q;
    logic          st_d, st_q;
    logic          tick;
    logic          tmr_wr;
    logic          st_clr;

    assign tick   = (pre_q == PW'(TIMER_DIV - 1));
    assign tmr_wr = we && per_sel && (off == 2'd1) && (be != 4'h0);
    assign st_clr = we && per_sel && (off == 2'd3) && be[0] && wdata[0];

    always_comb begin
        pre_d   = tick ? '0 : pre_q + 1'b1;
        timer_d = tick ? timer_q + 32'd1 : timer_q;
        cmp_d   = cmp_q;
        if (tmr_wr) begin
            pre_d   = '0;
            timer_d = (timer_q & ~bmask) | (wdata & bmask);
        end
        if (we && per_sel && (off == 2'd2)) begin
            cmp_d = (cmp_q & ~bmask) | (wdata & bmask);
        end
        // Compare the post-update count against the CMP already in place.
        st_d = (timer_d == cmp_q) | (st_q & ~st_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q   <= '0;
            timer_q <= '0;
            cmp_q   <= 32'hFFFF_FFFF;
            st_q    <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            timer_q <= timer_d;
            cmp_q   <= cmp_d;
            st_q    <= st_d;
        end
    end

    assign irq = st_q;
`else
    logic [15:0] unused_div;

    assign unused_div = 16'(TIMER_DIV);
    assign irq        = 1'b0;
`endif

    always_comb begin
        rdata_d = '0;
        if (ram_sel) begin
            rdata_d = mem[widx];
        end else if (per_sel) begin
            case (off)
                2'd0: rdata_d = {24'h0, gpio_q};
`ifdef RYSY_MEM_TIMER_EN
                2'd1: rdata_d = timer_q;
                2'd2: rdata_d = cmp_q;
                2'd3: rdata_d = {31'h0, st_q};
`endif
                default: rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        gpio_d = gpio_q;
        if (we && per_sel && (off == 2'd0) && be[0]) begin
            gpio_d = wdata[7:0];
        end
        err_d = err_q | ~(ram_sel | per_sel);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            gpio_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            gpio_q  <= gpio_d;
            err_q   <= err_d;
        end
    end

    assign rdata    = rdata_q;
    assign gpio_out = gpio_q;
    assign bus_err  = err_q;

endmodule
